// File: rtl/harness_pkg.sv
// Shared types and the write-classification rule for the processor test harness.
package harness_pkg;

    localparam int CLS_W = 64;

    typedef enum logic [2:0] {HOLD, RUN, PASS, FAIL, TIMEOUT} hstate_t;

    typedef enum logic [1:0] {V_NONE, V_PASS, V_FAIL, V_TIMEOUT} verdict_t;

    // Operands are zero-extended to CLS_W so one function serves any bus width.
    function automatic verdict_t classify(
        input logic [CLS_W-1:0] addr,
        input logic [CLS_W-1:0] data,
        input logic [CLS_W-1:0] passAddr,
        input logic [CLS_W-1:0] passData,
        input logic [CLS_W-1:0] ignoreAddr,
        input logic             strict
    );
        verdict_t v;
        v = V_NONE;
        if (addr == passAddr)
            v = (data == passData) ? V_PASS : V_FAIL;
        else if (addr != ignoreAddr && strict)
            v = V_FAIL;
        return v;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (en && q != '1)
            q <= q + 1'b1;
    end

endmodule

// File: rtl/harness_ctrl.sv
// Processor test harness: holds the CPU in reset, then watches its write port
// and latches a sticky pass / fail / timeout verdict with run statistics.
module harness_ctrl
    import harness_pkg::*;
#(
    parameter int                 ADDR_W       = 32,
    parameter int                 DATA_W       = 32,
    parameter int                 CNT_W        = 16,
    parameter int                 RESET_CYCLES = 3,
    parameter int                 MAX_CYCLES   = 160,
    parameter logic [ADDR_W-1:0]  PASS_ADDR    = ADDR_W'(100),
    parameter logic [DATA_W-1:0]  PASS_DATA    = DATA_W'(7),
    parameter logic [ADDR_W-1:0]  IGNORE_ADDR  = ADDR_W'(96),
    parameter logic               STRICT       = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] DataAdr,
    input  logic [DATA_W-1:0] WriteData,
    output logic              cpu_reset,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycles,
    output logic [CNT_W-1:0]  writes,
    output logic [ADDR_W-1:0] last_adr,
    output logic [DATA_W-1:0] last_data
);

    localparam int HOLD_W = 8;

    hstate_t           state;
    verdict_t          wrVerdict;
    logic [HOLD_W-1:0] holdCnt;
    logic              runCycle;
    logic              runWrite;
    logic              lastRun;

    assign runCycle = (state == RUN);
    assign runWrite = runCycle && MemWrite;
    assign lastRun  = (cycles == CNT_W'(MAX_CYCLES - 1));

    sat_counter #(.W(HOLD_W)) uHold (
        .clk(clk), .reset(reset), .en(state == HOLD), .q(holdCnt)
    );

    sat_counter #(.W(CNT_W)) uCycles (
        .clk(clk), .reset(reset), .en(runCycle), .q(cycles)
    );

    sat_counter #(.W(CNT_W)) uWrites (
        .clk(clk), .reset(reset), .en(runWrite), .q(writes)
    );

    // Gating on runWrite keeps an undriven bus from reaching the verdict.
    always_comb begin
        // NOTE: default first so no path through this block leaves wrVerdict
        // unassigned, which would otherwise infer a latch.
        wrVerdict = V_NONE;
        if (runWrite)
            wrVerdict = classify(CLS_W'(DataAdr), CLS_W'(WriteData),
                                 CLS_W'(PASS_ADDR), CLS_W'(PASS_DATA),
                                 CLS_W'(IGNORE_ADDR), STRICT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HOLD;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
            last_adr  <= '0;
            last_data <= '0;
        end else begin
            unique case (state)
                HOLD: begin
                    if (holdCnt == HOLD_W'(RESET_CYCLES - 1)) begin
                        state     <= RUN;
                        cpu_reset <= 1'b0;
                    end
                end
                RUN: begin
                    if (MemWrite) begin
                        last_adr  <= DataAdr;
                        last_data <= WriteData;
                    end
                    // A decisive write in the last budget cycle outranks the timeout.
                    if (wrVerdict == V_PASS) begin
                        state <= PASS;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end else if (wrVerdict == V_FAIL) begin
                        state <= FAIL;
                        done  <= 1'b1;
                        fail  <= 1'b1;
                    end else if (lastRun) begin
                        state   <= TIMEOUT;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_harness_ctrl.sv
// Randomized bench for harness_ctrl: a lenient and a strict instance share one
// bus; verdicts are predicted from a write schedule and scored on done's rise.
module tb_harness_ctrl;

    localparam int RC   = 3;
    localparam int MAXC = 160;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;

    logic        cpuReset0, done0, pass0, fail0, timeout0;
    logic [15:0] cycles0, writes0;
    logic [31:0] lastAdr0, lastData0;
    logic        cpuReset1, done1, pass1, fail1, timeout1;
    logic [15:0] cycles1, writes1;
    logic [31:0] lastAdr1, lastData1;

    always #5 clk = ~clk;

    harness_ctrl #(.STRICT(1'b0)) u0 (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .cpu_reset(cpuReset0), .done(done0), .pass(pass0),
        .fail(fail0), .timeout(timeout0), .cycles(cycles0), .writes(writes0),
        .last_adr(lastAdr0), .last_data(lastData0)
    );

    harness_ctrl #(.STRICT(1'b1)) u1 (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .cpu_reset(cpuReset1), .done(done1), .pass(pass1),
        .fail(fail1), .timeout(timeout1), .cycles(cycles1), .writes(writes1),
        .last_adr(lastAdr1), .last_data(lastData1)
    );

    // verdict: 1 pass, 2 fail, 3 timeout
    typedef struct {
        int          verdict;
        int          cyc;
        int          wr;
        logic [31:0] adr;
        logic [31:0] data;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] sAdr[int];
    logic [31:0] sData[int];
    int          passCnt = 0;
    int          totalCnt = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        totalCnt++;
        if (actual === expected)
            passCnt++;
        else
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, actual, expected, $time);
    endtask

    // Walks the run cycles in order; the first decisive write ends the run.
    function automatic exp_t model(input bit strict);
        exp_t e;
        e = '{verdict: 0, cyc: 0, wr: 0, adr: '0, data: '0};
        for (int c = 1; c <= MAXC; c++) begin
            if (sAdr.exists(c)) begin
                e.wr++;
                e.adr  = sAdr[c];
                e.data = sData[c];
                if (e.adr == 100)
                    e.verdict = (e.data == 7) ? 1 : 2;
                else if (e.adr != 96 && strict)
                    e.verdict = 2;
                if (e.verdict != 0) begin
                    e.cyc = c;
                    return e;
                end
            end
        end
        e.verdict = 3;
        e.cyc     = MAXC;
        return e;
    endfunction

    function automatic logic [2:0] flagsOf(input int v);
        return (v == 1) ? 3'b100 : (v == 2) ? 3'b010 : (v == 3) ? 3'b001 : 3'b000;
    endfunction

    task automatic scoreOne(input int id, input logic [2:0] flags, input logic [15:0] cyc,
                            input logic [15:0] wr, input logic [31:0] adr, input logic [31:0] data);
        exp_t e;
        int   n;
        n = (id == 0) ? q0.size() : q1.size();
        check($sformatf("dut%0d verdict was expected", id), n > 0, 1);
        if (n == 0) return;
        if (id == 0) e = q0.pop_front();
        else         e = q1.pop_front();
        check($sformatf("dut%0d flags {pass,fail,timeout}", id), flags, flagsOf(e.verdict));
        check($sformatf("dut%0d cycles", id), cyc, e.cyc);
        check($sformatf("dut%0d writes", id), wr, e.wr);
        check($sformatf("dut%0d last_adr", id), adr, e.adr);
        check($sformatf("dut%0d last_data", id), data, e.data);
    endtask

    logic prevDone0 = 1'b0;
    logic prevDone1 = 1'b0;

    always @(negedge clk) begin
        if (done0 && !prevDone0)
            scoreOne(0, {pass0, fail0, timeout0}, cycles0, writes0, lastAdr0, lastData0);
        if (done1 && !prevDone1)
            scoreOne(1, {pass1, fail1, timeout1}, cycles1, writes1, lastAdr1, lastData1);
        prevDone0 = done0;
        prevDone1 = done1;
    end

    task automatic addWr(input int c, input logic [31:0] a, input logic [31:0] d);
        sAdr[c]  = a;
        sData[c] = d;
    endtask

    // A write the harness would call a fail if it ever sampled it.
    task automatic driveTrap();
        MemWrite  = 1'b1;
        DataAdr   = 32'd100;
        WriteData = 32'd3;
    endtask

    task automatic driveRun(input int c);
        if (c > MAXC) begin
            driveTrap();
        end else if (sAdr.exists(c)) begin
            MemWrite  = 1'b1;
            DataAdr   = sAdr[c];
            WriteData = sData[c];
        end else begin
            MemWrite  = 1'b0;
            DataAdr   = 32'd100;
            WriteData = $urandom;
        end
    endtask

    // Entered and left on a falling edge; resetAt > 0 abandons the run after that RUN edge.
    task automatic runScenario(input int resetAt);
        exp_t e0, e1;
        int   endCyc;
        e0 = model(1'b0);
        e1 = model(1'b1);
        endCyc = ((e0.cyc > e1.cyc) ? e0.cyc : e1.cyc) + 3;
        if (resetAt == 0 || e0.cyc <= resetAt) q0.push_back(e0);
        if (resetAt == 0 || e1.cyc <= resetAt) q1.push_back(e1);

        reset     = 1'b1;
        MemWrite  = 1'b1;
        DataAdr   = 32'd100;
        WriteData = 32'd7;
        @(negedge clk);
        check("reset cpu_reset", cpuReset0, 1'b1);
        check("reset done/flags", {done0, pass0, fail0, timeout0}, 4'b0000);
        check("reset cycles/writes", {cycles0, writes0}, 32'd0);
        check("reset last_adr/last_data", {lastAdr0, lastData0}, 64'd0);
        check("reset strict cpu_reset/done", {cpuReset1, done1}, 2'b10);

        reset = 1'b0;
        driveTrap();
        for (int h = 0; h < RC; h++) begin
            @(negedge clk);
            check($sformatf("hold edge %0d cpu_reset", h), cpuReset0, (h < RC - 1) ? 1'b1 : 1'b0);
            if (h == RC - 1) check("cycles idle through hold", cycles0, 16'd0);
            if (h < RC - 1) driveTrap();
            else            driveRun(1);
        end

        for (int c = 1; c <= endCyc; c++) begin
            @(negedge clk);
            if (c == 1) check("first run edge cycles", cycles0, 16'd1);
            if (c == resetAt) return;
            driveRun(c + 1);
        end

        check("frozen cycles", cycles0, e0.cyc);
        check("frozen writes", writes0, e0.wr);
        check("frozen last_adr", lastAdr0, e0.adr);
        check("frozen strict cycles", cycles1, e1.cyc);
        check("frozen cpu_reset", {cpuReset0, cpuReset1}, 2'b00);
    endtask

    initial begin
        int n, c, r, resetAt;
        logic [31:0] a, d;
        @(negedge clk);

        sAdr.delete(); sData.delete();
        addWr(20, 32'd100, 32'd7);
        runScenario(0);

        sAdr.delete(); sData.delete();
        addWr(10, 32'd96, 32'd5);
        addWr(30, 32'd100, 32'd3);
        runScenario(0);

        sAdr.delete(); sData.delete();
        addWr(15, 32'd200, 32'd7);
        runScenario(0);

        sAdr.delete(); sData.delete();
        runScenario(0);

        sAdr.delete(); sData.delete();
        addWr(50, 32'd96, 32'd1);
        addWr(MAXC, 32'd100, 32'd7);
        runScenario(0);

        sAdr.delete(); sData.delete();
        addWr(MAXC, 32'd100, 32'd3);
        runScenario(0);

        sAdr.delete(); sData.delete();
        addWr(5, 32'd96, 32'd2);
        runScenario(40);

        for (int s = 0; s < 12; s++) begin
            sAdr.delete(); sData.delete();
            n = $urandom_range(0, 4);
            for (int k = 0; k < n; k++) begin
                c = $urandom_range(1, MAXC);
                r = $urandom_range(0, 9);
                if (r < 4)      a = 32'd96;
                else if (r < 6) a = 32'd100;
                else            a = $urandom_range(0, 1000);
                d = ($urandom_range(0, 1) == 1) ? 32'd7 : 32'($urandom_range(0, 20));
                addWr(c, a, d);
            end
            resetAt = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 150) : 0;
            runScenario(resetAt);
        end

        @(negedge clk);
        check("dut0 scoreboard drained", q0.size(), 0);
        check("dut1 scoreboard drained", q1.size(), 0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
